clk_rate_sequencer: RTL and testbench



---
 rtl/clk_rate_pkg.sv | 37 +++
 rtl/sw_debounce.sv | 51 +++++
 rtl/clk_rate_sequencer.sv | 104 ++++++++++
 tb/tb_clk_rate_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rate_pkg.sv
// Shared encodings and helpers for the clock-rate sequencer.
package clk_rate_pkg;

    // Active rate encodings as seen on rateSel.
    localparam logic [1:0] RATE_SLOW = 2'b00;
    localparam logic [1:0] RATE_MED  = 2'b01;
    localparam logic [1:0] RATE_FAST = 2'b10;

    // RUN: rate is settled. PENDING: a new rate waits for the next period wrap.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } seq_state_e;

    // Tick period in clk cycles for a given rate; the unused code falls back to slow.
    function automatic int rate_div(input logic [1:0] rate,
                                    input int div_fast,
                                    input int div_med,
                                    input int div_slow);
        case (rate)
            RATE_FAST: return div_fast;
            RATE_MED:  return div_med;
            default:   return div_slow;
        endcase
    endfunction

    // Switch pattern {sw2,sw1} to requested rate; 01 is not a request and keeps prev.
    function automatic logic [1:0] sw_decode(input logic [1:0] sw, input logic [1:0] prev);
        case (sw)
            2'b00:   return RATE_SLOW;
            2'b10:   return RATE_MED;
            2'b11:   return RATE_FAST;
            default: return prev;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a stability counter. The output only
// takes a new value after the synchronized vector has held it for
// DEB_CYCLES consecutive clocks; any change restarts the count.
module sw_debounce #(
    parameter int W          = 2,
    parameter int DEB_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int CNTW = $clog2(DEB_CYCLES + 1);

    logic [W-1:0]    sync1;
    logic [W-1:0]    sync2;
    logic [W-1:0]    prev;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;

    // Count of consecutive samples equal to the previous one, saturating at DEB_CYCLES.
    always_comb begin
        cnt_nxt = cnt;
        if (sync2 != prev) begin
            cnt_nxt = CNTW'(1);
        end else if (cnt < CNTW'(DEB_CYCLES)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Synchronizer, history and accepted-value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_nxt;
            if (cnt_nxt == CNTW'(DEB_CYCLES)) begin
                dout <= sync2;
            end
        end
    end

endmodule

// File: rtl/clk_rate_sequencer.sv
// Generates a one-cycle clock enable at one of three rates selected by the
// board switches. Rate changes are deferred to a period wrap so every tick
// period is exactly one divisor long. The FSM state is held in `state` so
// checkers can bind to it directly.
module clk_rate_sequencer
    import clk_rate_pkg::*;
#(
    parameter int DIV_FAST   = 4,
    parameter int DIV_MEDIUM = 16,
    parameter int DIV_SLOW   = 64,
    parameter int DEB_CYCLES = 8,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw2,
    input  logic       sw1,
    output logic       tick,
    output logic [1:0] rateSel,
    output logic       busy,
    output logic       changeStrobe
);

    logic [1:0]    deb;
    logic [1:0]    target;
    logic [1:0]    target_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] div_m1;
    logic          wrap;
    logic          do_switch;
    seq_state_e    state;
    seq_state_e    state_nxt;

    sw_debounce #(
        .W          (2),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .din  ({sw2, sw1}),
        .dout (deb)
    );

    // The request is visible to the FSM the same cycle the debounced value lands.
    assign target_nxt = sw_decode(deb, target);
    assign div_m1     = CW'(rate_div(rateSel, DIV_FAST, DIV_MEDIUM, DIV_SLOW) - 1);
    assign wrap       = (cnt == div_m1);
    assign busy       = (state == ST_PENDING);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a cancelled request takes priority over a switch on the same wrap.
    always_comb begin
        state_nxt = state;
        do_switch = 1'b0;
        case (state)
            ST_RUN: begin
                if (target_nxt != rateSel) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (target_nxt == rateSel) begin
                    state_nxt = ST_RUN;
                end else if (wrap) begin
                    state_nxt = ST_RUN;
                    do_switch = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Period counter, registered tick/strobe and the active rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            tick         <= 1'b0;
            changeStrobe <= 1'b0;
            rateSel      <= RATE_SLOW;
            target       <= RATE_SLOW;
        end else begin
            target       <= target_nxt;
            tick         <= wrap;
            changeStrobe <= do_switch;
            if (wrap) begin
                cnt <= '0;
                if (do_switch) begin
                    rateSel <= target_nxt;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_rate_sequencer.sv
// Directed bench for clk_rate_sequencer with default parameters
// (DIV 4/16/64, DEB_CYCLES 8).
module tb_clk_rate_sequencer;

    logic       clk;
    logic       rst;
    logic       sw2;
    logic       sw1;
    logic       tick;
    logic [1:0] rateSel;
    logic       busy;
    logic       changeStrobe;

    int checks = 0;
    int errors = 0;

    clk_rate_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .sw2          (sw2),
        .sw1          (sw1),
        .tick         (tick),
        .rateSel      (rateSel),
        .busy         (busy),
        .changeStrobe (changeStrobe)
    );

    // Clock generation, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until tick is seen (n = edges taken, -1 on timeout), noting busy/strobe.
    task automatic wait_tick(input int max, output int n, output logic b_seen, output logic s_seen);
        n = -1;
        b_seen = 1'b0;
        s_seen = 1'b0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (busy) b_seen = 1'b1;
            if (changeStrobe) s_seen = 1'b1;
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    // Drive a switch value and wait for the resulting rate change.
    task automatic settle(input logic [1:0] v, input logic [1:0] exp_rate);
        logic found;
        found = 1'b0;
        sw2 = v[1];
        sw1 = v[0];
        for (int i = 0; i < 300; i++) begin
            step();
            if (changeStrobe) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL settle_strobe: got %b expected 1 (sw=%b)", found, v);
        end
        checks++;
        if (rateSel !== exp_rate || tick !== 1'b1) begin
            errors++;
            $display("FAIL settle_rate: got rate=%b tick=%b expected rate=%b tick=1", rateSel, tick, exp_rate);
        end
    endtask

    task automatic test_reset();
        int n;
        logic b, s;
        rst = 1'b1;
        sw2 = 1'b0;
        sw1 = 1'b0;
        repeat (3) step();
        checks++;
        if ({tick, rateSel, busy, changeStrobe} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", {tick, rateSel, busy, changeStrobe});
        end
        rst = 1'b0;
        wait_tick(200, n, b, s);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL reset_first_tick: got %0d expected 64", n);
        end
        step();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: got %b expected 0", tick);
        end
        wait_tick(200, n, b, s);
        checks++;
        if (n !== 63 || b !== 1'b0 || s !== 1'b0 || rateSel !== 2'b00) begin
            errors++;
            $display("FAIL slow_period: got n=%0d busy=%b strobe=%b rate=%b expected 63 0 0 00", n, b, s, rateSel);
        end
    endtask

    task automatic test_slow_to_fast();
        int n;
        logic b, s;
        sw2 = 1'b1;
        sw1 = 1'b1;
        repeat (10) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fast_busy_early: got %b expected 0", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1 || rateSel !== 2'b00) begin
            errors++;
            $display("FAIL fast_busy_rise: got busy=%b rate=%b expected 1 00", busy, rateSel);
        end
        wait_tick(100, n, b, s);
        checks++;
        if (n !== 53 || changeStrobe !== 1'b1 || rateSel !== 2'b10) begin
            errors++;
            $display("FAIL fast_switch: got n=%0d strobe=%b rate=%b expected 53 1 10", n, changeStrobe, rateSel);
        end
        step();
        checks++;
        if (changeStrobe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fast_after: got strobe=%b busy=%b expected 0 0", changeStrobe, busy);
        end
        wait_tick(100, n, b, s);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL fast_period1: got %0d expected 3", n);
        end
        wait_tick(100, n, b, s);
        checks++;
        if (n !== 4 || s !== 1'b0) begin
            errors++;
            $display("FAIL fast_period2: got n=%0d strobe=%b expected 4 0", n, s);
        end
    endtask

    task automatic test_glitch();
        int n;
        logic b, s, b_pulse;
        settle(2'b00, 2'b00);
        b_pulse = 1'b0;
        sw2 = 1'b0;
        sw1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) b_pulse = 1'b1;
        end
        sw1 = 1'b0;
        wait_tick(100, n, b, s);
        checks++;
        if (n !== 61 || (b | b_pulse) !== 1'b0 || rateSel !== 2'b00) begin
            errors++;
            $display("FAIL glitch_sw1: got n=%0d busy=%b rate=%b expected 61 0 00", n, b | b_pulse, rateSel);
        end
        b_pulse = 1'b0;
        sw2 = 1'b1;
        sw1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (busy) b_pulse = 1'b1;
        end
        sw2 = 1'b0;
        sw1 = 1'b0;
        wait_tick(100, n, b, s);
        checks++;
        if (n !== 57 || (b | b_pulse) !== 1'b0 || s !== 1'b0 || rateSel !== 2'b00) begin
            errors++;
            $display("FAIL glitch_7cyc: got n=%0d busy=%b strobe=%b rate=%b expected 57 0 0 00", n, b | b_pulse, s, rateSel);
        end
    endtask

    task automatic test_medium_hold();
        int n;
        logic b, s;
        settle(2'b10, 2'b01);
        sw2 = 1'b0;
        sw1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick(100, n, b, s);
            checks++;
            if (n !== 16 || b !== 1'b0 || s !== 1'b0 || rateSel !== 2'b01) begin
                errors++;
                $display("FAIL medium_hold[%0d]: got n=%0d busy=%b strobe=%b rate=%b expected 16 0 0 01", k, n, b, s, rateSel);
            end
        end
    endtask

    task automatic test_cancel();
        int n;
        logic b, s;
        settle(2'b00, 2'b00);
        sw2 = 1'b1;
        sw1 = 1'b1;
        repeat (11) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_busy_rise: got %b expected 1", busy);
        end
        sw2 = 1'b0;
        sw1 = 1'b0;
        repeat (10) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_busy_hold: got %b expected 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || changeStrobe !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy_fall: got busy=%b strobe=%b expected 0 0", busy, changeStrobe);
        end
        wait_tick(100, n, b, s);
        checks++;
        if (n !== 42 || s !== 1'b0 || rateSel !== 2'b00) begin
            errors++;
            $display("FAIL cancel_wrap: got n=%0d strobe=%b rate=%b expected 42 0 00", n, s, rateSel);
        end
        wait_tick(100, n, b, s);
        checks++;
        if (n !== 64 || s !== 1'b0 || b !== 1'b0) begin
            errors++;
            $display("FAIL cancel_period: got n=%0d strobe=%b busy=%b expected 64 0 0", n, s, b);
        end
    endtask

    task automatic test_reset_pending();
        int n;
        logic b, s;
        sw2 = 1'b1;
        sw1 = 1'b1;
        repeat (11) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstpend_busy: got %b expected 1", busy);
        end
        #2;
        rst = 1'b1;
        sw2 = 1'b0;
        sw1 = 1'b0;
        #1;
        checks++;
        if ({tick, rateSel, busy, changeStrobe} !== 5'b00000) begin
            errors++;
            $display("FAIL rstpend_async: got %b expected 00000", {tick, rateSel, busy, changeStrobe});
        end
        step();
        rst = 1'b0;
        wait_tick(200, n, b, s);
        checks++;
        if (n !== 64 || b !== 1'b0 || s !== 1'b0 || rateSel !== 2'b00) begin
            errors++;
            $display("FAIL rstpend_first_tick: got n=%0d busy=%b strobe=%b rate=%b expected 64 0 0 00", n, b, s, rateSel);
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        rst = 1'b1;
        sw2 = 1'b0;
        sw1 = 1'b0;
        test_reset();
        test_slow_to_fast();
        test_glitch();
        test_medium_hold();
        test_cancel();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
